block_dispenser: RTL and testbench
==================================

Name: block_dispenser

Overview:
Consumer end of the free-running block-type generator. Samples the 2-bit random code (legal values 1..3) and keeps a preview queue of upcoming block types. Hands one block type to the game controller per spawn handshake and exposes the queue contents for the "next piece" display. Sits between the block-type generator and the playfield/spawn logic.

Parameters:
DEPTH, 4, preview queue depth in entries (2..8).
TYPE_W, 2, width of one block-type code.

Ports:
clk  in  1  system clock (100 MHz).
rst_n  in  1  asynchronous active-low reset.
random  in  TYPE_W  free-running block code from the generator; 0 = illegal/none.
spawn_req  in  1  game controller requests the next block; level-sensitive.
spawn_valid  out  1  head entry present; spawn_type is meaningful.
spawn_type  out  TYPE_W  head-of-queue block type.
preview  out  DEPTH*TYPE_W  queue contents; entry 0 (head) in the LSBs; empty slots read 0.
count  out  clog2(DEPTH+1)  number of valid entries.
underflow  out  1  sticky flag: spawn_req seen while spawn_valid=0.

Behaviour:
- Reset (async assert, sync release): count=0, queue cleared to 0, spawn_valid=0, spawn_type=0, preview=0, underflow=0, state=FILL.
- All outputs are registered; spawn_type, spawn_valid and preview are driven directly from queue registers.
- Sampling rule: in a given cycle, random is "acceptable" iff random != 0 (and the optional-feature rule below allows it). An acceptable value is pushed at the tail only if, after any pop in that cycle, a slot is free.
- Pop: a transfer occurs when spawn_req=1 and spawn_valid=1 on a clock edge.
  - On a transfer, the head is removed and entries shift toward the head.
  - The caller samples spawn_type in the same cycle as the transfer.
  - If spawn_req is held high, one block is popped every cycle.
- Simultaneous pop and push:
  - When full: pop the head and push at the tail; count stays at DEPTH.
  - When count=1: the new value becomes the head next cycle; spawn_valid stays 1.
- State machine:
  - FILL: count<DEPTH. Push every acceptable cycle. Moves to FULL when count reaches DEPTH.
  - FULL: count=DEPTH. No push unless a pop occurs in the same cycle. Moves to FILL when a pop happens without an accompanying push.
- Latency:
  - From reset release, the first entry is valid 1 cycle after the first acceptable sample.
  - The queue is full after DEPTH acceptable samples; with random never 0, that is DEPTH cycles.
- Underflow: spawn_req=1 with spawn_valid=0 sets underflow. Nothing is popped, and underflow stays set until reset.
- Width rules: count saturates logically at DEPTH (never exceeds it); preview slots beyond count are forced to 0.
- Reset mid-operation clears the queue immediately; no partial pop survives.

Optional Feature:
Macro: BLOCK_NO_REPEAT_EN.
- Defined: an acceptable sample must also differ from the most recently pushed value, held in a last_pushed register (reset 0). A matching sample is skipped that cycle, so no two consecutive queue entries are equal. Because the generator cycles 1,2,3, a skip delays filling by at most 1 cycle.
- Undefined: any nonzero sample is accepted and the last_pushed register is absent.

Decomposition:
- Shared package tetris_pkg:
  - TYPE_W.
  - Block-type constants BLK_NONE=0, BLK_1=1, BLK_2=2, BLK_3=3.
  - DEPTH default.
  - State encoding localparams S_FILL, S_FULL.
- One sub-module is natural: block_shift_queue, a DEPTH-entry shift-register queue with push, pop and count that drives preview. block_dispenser wraps it with the sampling rule, the state machine, underflow and the optional no-repeat filter.

Test Plan:
- Reset fill: release rst_n, random cycles 1,2,3,1,... → count rises 1,2,3,4 on consecutive cycles; preview = {1,3,2,1} MSB→LSB; spawn_valid=1 from cycle 1; state FULL.
- Illegal code: hold random=0 for 5 cycles after reset, then random=2 → count stays 0 for 5 cycles, spawn_valid=0, then count=1 and spawn_type=2.
- Pop while full: full queue {1,3,2,1}; pulse spawn_req 1 cycle with random=3 → spawn_type=1 on the transfer cycle; next cycle queue {3,1,3,2}, count=4.
- Back-to-back drain: hold random=0 and spawn_req=1 for 5 cycles from full → 4 transfers with count 3,2,1,0, then underflow=1 in cycle 5; underflow remains 1 until rst_n=0.
- Async reset mid-run: assert rst_n low between clock edges while count=3 → spawn_valid, count and preview go to 0 without waiting for a clock edge.
- BLOCK_NO_REPEAT_EN defined: random sequence 2,2,2,3,3,1 → pushes 2,3,1 only; no adjacent equal preview entries.

Source files
------------

// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tetris_pkg
// Description : Shared types and constants for the block-type path: code
//               width, block-type codes, default preview depth and the
//               dispenser state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    localparam int TYPE_W = 2;
    localparam int DEPTH  = 4;

    localparam logic [TYPE_W-1:0] BLK_NONE = 2'd0;
    localparam logic [TYPE_W-1:0] BLK_1    = 2'd1;
    localparam logic [TYPE_W-1:0] BLK_2    = 2'd2;
    localparam logic [TYPE_W-1:0] BLK_3    = 2'd3;

    localparam logic S_FILL = 1'b0;
    localparam logic S_FULL = 1'b1;

    typedef enum logic {
        ST_FILL = S_FILL,
        ST_FULL = S_FULL
    } state_t;

endpackage : tetris_pkg
`default_nettype wire

// File: rtl/block_shift_queue.sv
`default_nettype none
// ============================================================================
// Module      : block_shift_queue
// Description : DEPTH-entry shift-register queue. Entry 0 is the head; a pop
//               shifts every entry one slot toward the head. Slots at or
//               beyond count always hold 0, so preview needs no masking.
// Ports       : clk, rst_n       - clock, async active-low reset
//               push, din        - append din at the tail
//               pop              - remove the head
//               head, head_valid - registered head entry and its valid flag
//               preview          - all entries, entry 0 in the LSBs
//               count            - number of valid entries
// Revision    : 1.0 - initial release
// ============================================================================
module block_shift_queue #(
    parameter int DEPTH  = 4,
    parameter int TYPE_W = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [TYPE_W-1:0]       din,
    output logic [TYPE_W-1:0]       head,
    output logic                    head_valid,
    output logic [DEPTH*TYPE_W-1:0] preview,
    output logic [CNT_W-1:0]        count
);

    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    logic [TYPE_W-1:0] r_q [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic              r_valid;

    logic [TYPE_W-1:0] w_q_next [DEPTH];
    logic [CNT_W-1:0]  w_count_next;
    logic [CNT_W-1:0]  w_wr_idx;
    logic              w_do_pop;
    logic              w_do_push;

    always_comb begin
        w_do_pop  = pop && (r_count != '0);
        // A push needs a free slot once any same-cycle pop has been applied.
        w_do_push = push && (w_do_pop || (r_count != c_full));
        for (int i = 0; i < DEPTH; i++) begin
            w_q_next[i] = r_q[i];
        end
        if (w_do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_q_next[i] = r_q[i + 1];
            end
            w_q_next[DEPTH-1] = '0;
        end
        // Tail position moves down by one when the head leaves this cycle.
        w_wr_idx = w_do_pop ? (r_count - CNT_W'(1)) : r_count;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_do_push && (CNT_W'(i) == w_wr_idx)) begin
                w_q_next[i] = din;
            end
        end
        w_count_next = r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= '0;
            end
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= w_q_next[i];
            end
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);
        end
    end

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_preview
            assign preview[g*TYPE_W +: TYPE_W] = r_q[g];
        end
    endgenerate

    assign head       = r_q[0];
    assign head_valid = r_valid;
    assign count      = r_count;

endmodule : block_shift_queue
`default_nettype wire

// File: rtl/block_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : block_dispenser
// Description : Samples the free-running block-type code, keeps a preview
//               queue of upcoming blocks and hands one block to the game
//               controller per spawn handshake (spawn_req && spawn_valid).
//               Build option BLOCK_NO_REPEAT_EN: skip a sample equal to the
//               most recently queued block so adjacent entries differ.
// Ports       : clk, rst_n   - clock, async active-low reset
//               random       - generator code, 0 = none
//               spawn_req    - level-sensitive request for the next block
//               spawn_valid  - head entry present
//               spawn_type   - head block type
//               preview      - queue contents, head in the LSBs
//               count        - valid entries
//               underflow    - sticky: request seen while empty
// Revision    : 1.0 - initial release
// ============================================================================
module block_dispenser
    import tetris_pkg::*;
#(
    parameter int DEPTH  = tetris_pkg::DEPTH,
    parameter int TYPE_W = tetris_pkg::TYPE_W,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [TYPE_W-1:0]       random,
    input  logic                    spawn_req,
    output logic                    spawn_valid,
    output logic [TYPE_W-1:0]       spawn_type,
    output logic [DEPTH*TYPE_W-1:0] preview,
    output logic [CNT_W-1:0]        count,
    output logic                    underflow
);

    localparam logic [CNT_W-1:0] c_full = CNT_W'(DEPTH);

    state_t           r_state;
    logic             r_underflow;
    logic             w_transfer;
    logic             w_acceptable;
    logic             w_push;
    logic [CNT_W-1:0] w_count_next;

`ifdef BLOCK_NO_REPEAT_EN
    logic [TYPE_W-1:0] r_last_pushed;
    assign w_acceptable = (random != '0) && (random != r_last_pushed);
`else
    assign w_acceptable = (random != '0);
`endif

    assign w_transfer = spawn_req && spawn_valid;
    // When full, a sample fits only into the slot freed by a same-cycle pop.
    assign w_push     = w_acceptable && ((r_state == ST_FILL) || w_transfer);

    assign w_count_next = count + CNT_W'(w_push) - CNT_W'(w_transfer);

    block_shift_queue #(
        .DEPTH  (DEPTH),
        .TYPE_W (TYPE_W)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .pop        (w_transfer),
        .din        (random),
        .head       (spawn_type),
        .head_valid (spawn_valid),
        .preview    (preview),
        .count      (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_FILL;
            r_underflow <= 1'b0;
`ifdef BLOCK_NO_REPEAT_EN
            r_last_pushed <= '0;
`endif
        end else begin
            case (r_state)
                ST_FILL: if (w_count_next == c_full) r_state <= ST_FULL;
                ST_FULL: if (w_count_next != c_full) r_state <= ST_FILL;
                default: r_state <= ST_FILL;
            endcase
            if (spawn_req && !spawn_valid) begin
                r_underflow <= 1'b1;
            end
`ifdef BLOCK_NO_REPEAT_EN
            if (w_push) begin
                r_last_pushed <= random;
            end
`endif
        end
    end

    assign underflow = r_underflow;

endmodule : block_dispenser
`default_nettype wire

// File: tb/tb_block_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : tb_block_dispenser
// Description : Self-checking bench for block_dispenser. A queue-based model
//               predicts the block list; expected handshake results go to a
//               scoreboard that a negedge monitor drains on each transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_block_dispenser;

    localparam int DEPTH  = 4;
    localparam int TYPE_W = 2;
    localparam int CW     = $clog2(DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [TYPE_W-1:0]       random = '0;
    logic                    spawn_req = 1'b0;
    logic                    spawn_valid;
    logic [TYPE_W-1:0]       spawn_type;
    logic [DEPTH*TYPE_W-1:0] preview;
    logic [CW-1:0]           count;
    logic                    underflow;

    always #5 clk = ~clk;

    block_dispenser #(.DEPTH(DEPTH), .TYPE_W(TYPE_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .random      (random),
        .spawn_req   (spawn_req),
        .spawn_valid (spawn_valid),
        .spawn_type  (spawn_type),
        .preview     (preview),
        .count       (count),
        .underflow   (underflow)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the list of queued block types, head first.
    logic [TYPE_W-1:0] model [$];
    logic [TYPE_W-1:0] exp_q [$];
    logic [TYPE_W-1:0] m_last = '0;
    logic              m_underflow = 1'b0;
    bit                mon_en = 1'b0;

    logic [CW-1:0]           s_count = '0;
    logic [DEPTH*TYPE_W-1:0] s_preview = '0;
    logic                    s_valid = 1'b0;
    logic [TYPE_W-1:0]       s_type = '0;
    logic                    s_under = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic snapshot();
        s_count   = CW'(model.size());
        s_preview = '0;
        foreach (model[i]) s_preview[i*TYPE_W +: TYPE_W] = model[i];
        s_valid   = (model.size() > 0);
        s_type    = (model.size() > 0) ? model[0] : '0;
        s_under   = m_underflow;
    endtask

    // Effect of one clock edge with the given inputs on the block list.
    task automatic model_edge(input logic [TYPE_W-1:0] r, input logic req);
        bit acc;
        if (req) begin
            if (model.size() > 0) void'(model.pop_front());
            else m_underflow = 1'b1;
        end
        acc = (r != 0);
`ifdef BLOCK_NO_REPEAT_EN
        acc = acc && (r != m_last);
`endif
        if (acc && model.size() < DEPTH) begin
            model.push_back(r);
            m_last = r;
        end
        snapshot();
    endtask

    // Called just after a rising edge: drive inputs for one cycle.
    task automatic step(input logic [TYPE_W-1:0] r, input logic req);
        random    = r;
        spawn_req = req;
        if (req && model.size() > 0) exp_q.push_back(model[0]);
        @(posedge clk);
        #1;
        model_edge(r, req);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        random    = '0;
        spawn_req = 1'b0;
        #2;
        rst_n = 1'b0;
        model.delete();
        exp_q.delete();
        m_last      = '0;
        m_underflow = 1'b0;
        snapshot();
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_valid", 32'(spawn_valid), 32'd0);
        check("async_rst_preview", 32'(preview), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("count", 32'(count), 32'(s_count));
            check("preview", 32'(preview), 32'(s_preview));
            check("spawn_valid", 32'(spawn_valid), 32'(s_valid));
            check("spawn_type", 32'(spawn_type), 32'(s_type));
            check("underflow", 32'(underflow), 32'(s_under));
            if (spawn_req && spawn_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL transfer: got type %0h expected no transfer at %0t", spawn_type, $time);
                end else begin
                    check("transfer_type", 32'(spawn_type), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        snapshot();
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Fill from reset with the generator's 1,2,3,1 sequence.
        step(2'd1, 1'b0);
        check("fill_first_valid", 32'(spawn_valid), 32'd1);
        step(2'd2, 1'b0);
        step(2'd3, 1'b0);
        step(2'd1, 1'b0);
        check("fill_count", 32'(count), 32'd4);
        check("fill_preview", 32'(preview), 32'h79);
        step(2'd2, 1'b0);
        check("full_hold", 32'(preview), 32'h79);

        // Single pop while full, with a simultaneous push.
        step(2'd3, 1'b1);
        check("pop_full_preview", 32'(preview), 32'hDE);
        check("pop_full_count", 32'(count), 32'd4);

        // Drain back to back, then request once more while empty.
        for (int i = 0; i < 5; i++) step(2'd0, 1'b1);
        check("drain_underflow", 32'(underflow), 32'd1);
        step(2'd0, 1'b0);
        step(2'd1, 1'b0);
        check("underflow_sticky", 32'(underflow), 32'd1);
        do_reset();
        check("underflow_cleared", 32'(underflow), 32'd0);

        // Illegal code for 5 cycles, then a legal one.
        for (int i = 0; i < 5; i++) step(2'd0, 1'b0);
        check("illegal_count", 32'(count), 32'd0);
        step(2'd2, 1'b0);
        check("legal_count", 32'(count), 32'd1);
        check("legal_type", 32'(spawn_type), 32'd2);

        // Reset mid-run with three entries queued.
        step(2'd1, 1'b0);
        step(2'd3, 1'b0);
        check("pre_reset_count", 32'(count), 32'd3);
        do_reset();

        // Repeated codes.
        step(2'd2, 1'b0);
        step(2'd2, 1'b0);
        step(2'd2, 1'b0);
        step(2'd3, 1'b0);
        step(2'd3, 1'b0);
        step(2'd1, 1'b0);
`ifdef BLOCK_NO_REPEAT_EN
        check("norep_preview", 32'(preview), 32'h1E);
`else
        check("rep_preview", 32'(preview), 32'hEA);
`endif
        do_reset();

        // Randomized traffic with occasional mid-run resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step(TYPE_W'($urandom_range(0, 3)), ($urandom_range(0, 9) < 4));
            end
        end
        step(2'd0, 1'b0);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_block_dispenser
`default_nettype wire
